// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned CONV_LAT = 4;
  localparam int unsigned PROD_W   = 2 * PIX_W;
  // Three 16-bit products need two extra bits for the row sum.
  localparam int unsigned ROW_W    = PROD_W + 2;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [PIX_W-1:0]  weight_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [ROW_W-1:0]  row_sum_t;
  typedef logic [ACC_W-1:0]  acc_t;

  function automatic acc_t add3(row_sum_t a, row_sum_t b, row_sum_t c);
    return ACC_W'(a) + ACC_W'(b) + ACC_W'(c);
  endfunction

endpackage

// File: rtl/conv_3x3_systolic_if.sv
// Column-in / result-out stream bundle of the 3x3 convolution engine.
interface conv_3x3_systolic_if;
  import conv_pkg::*;

  logic in_valid;
  pix_t px0;
  pix_t px1;
  pix_t px2;
  logic out_valid;
  acc_t out_pixel;

  modport master (
    output in_valid, px0, px1, px2,
    input  out_valid, out_pixel
  );

  modport slave (
    input  in_valid, px0, px1, px2,
    output out_valid, out_pixel
  );

endinterface

// File: rtl/conv_row_pe.sv
// One kernel row: input register, 3-tap horizontal shift register, three
// registered products and a registered row partial sum.
module conv_row_pe
  import conv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  logic     shift,
  input  pix_t     px,
  input  weight_t  k0,
  input  weight_t  k1,
  input  weight_t  k2,
  output row_sum_t row_sum
);

  pix_t            px_q;
  pix_t  [2:0]     tap_q;
  prod_t [2:0]     prod_q;
  row_sum_t        sum_q;

  // tap_q[0] is the oldest column and pairs with k0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_q   <= '0;
      tap_q  <= '0;
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      if (in_valid) px_q <= px;
      if (shift) begin
        tap_q[0] <= tap_q[1];
        tap_q[1] <= tap_q[2];
        tap_q[2] <= px_q;
      end
      prod_q[0] <= PROD_W'(k0) * PROD_W'(tap_q[0]);
      prod_q[1] <= PROD_W'(k1) * PROD_W'(tap_q[1]);
      prod_q[2] <= PROD_W'(k2) * PROD_W'(tap_q[2]);
      sum_q     <= ROW_W'(prod_q[0]) + ROW_W'(prod_q[1]) + ROW_W'(prod_q[2]);
    end
  end

  assign row_sum = sum_q;

endmodule

// File: rtl/conv_3x3_systolic.sv
// Streaming 3x3 convolution: column counter, window-valid pipeline, three row
// PEs and the final adder into the output register.
module conv_3x3_systolic
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  conv_3x3_systolic_if.slave bus,
  input  weight_t            k00,
  input  weight_t            k01,
  input  weight_t            k02,
  input  weight_t            k10,
  input  weight_t            k11,
  input  weight_t            k12,
  input  weight_t            k20,
  input  weight_t            k21,
  input  weight_t            k22
);

  localparam int unsigned      COL_W   = $clog2(IMG_W);
  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);

  logic [COL_W-1:0]    col_q, col_d;
  logic                win_in;
  logic                shift_q;
  logic [CONV_LAT-1:0] win_q;
  logic                out_valid_q;
  acc_t                out_pixel_q;
  row_sum_t            sum0, sum1, sum2;

  always_comb begin
    col_d = col_q;
    if (bus.in_valid) col_d = (col_q == ColLast) ? '0 : col_q + COL_W'(1);
  end

  // Only the third and later columns of a row complete a window.
  assign win_in = bus.in_valid && (col_q >= COL_W'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      shift_q     <= 1'b0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      col_q       <= col_d;
      shift_q     <= bus.in_valid;
      win_q       <= {win_q[CONV_LAT-2:0], win_in};
      out_valid_q <= win_q[CONV_LAT-1];
      if (win_q[CONV_LAT-1]) out_pixel_q <= add3(sum0, sum1, sum2);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;

  conv_row_pe u_row0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .shift    (shift_q),
    .px       (bus.px0),
    .k0       (k00),
    .k1       (k01),
    .k2       (k02),
    .row_sum  (sum0)
  );

  conv_row_pe u_row1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .shift    (shift_q),
    .px       (bus.px1),
    .k0       (k10),
    .k1       (k11),
    .k2       (k12),
    .row_sum  (sum1)
  );

  conv_row_pe u_row2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .shift    (shift_q),
    .px       (bus.px2),
    .k0       (k20),
    .k1       (k21),
    .k2       (k22),
    .row_sum  (sum2)
  );

endmodule

// File: tb/tb_conv_3x3_systolic.sv
// Directed bench for conv_3x3_systolic: ramp image, saturation range, stall,
// mid-row reset and zero kernel, checked with immediate assertions.
module tb_conv_3x3_systolic;
  import conv_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  weight_t k [9];

  always #5 clk = ~clk;

  conv_3x3_systolic_if bus ();

  conv_3x3_systolic #(
    .IMG_W (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .k00 (k[0]),
    .k01 (k[1]),
    .k02 (k[2]),
    .k10 (k[3]),
    .k11 (k[4]),
    .k12 (k[5]),
    .k20 (k[6]),
    .k21 (k[7]),
    .k22 (k[8])
  );

  int          cyc = 0;
  logic [23:0] got_v [$];
  int          got_t [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result log: value and index of the edge that registered it.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      got_v.push_back(bus.out_pixel);
      got_t.push_back(cyc);
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(int y, int x);
    return 7 * y + x + 1;
  endfunction

  task automatic send(int a, int b, int c);
    bus.in_valid = 1'b1;
    bus.px0      = 8'(a);
    bus.px1      = 8'(b);
    bus.px2      = 8'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.px0      = 8'hAA;
      bus.px1      = 8'h55;
      bus.px2      = 8'hAA;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_ramp(int stall_pos, int stall_len);
    for (int n = 0; n < 28; n++) begin
      if (n == stall_pos) idle(stall_len);
      send(pix(n / 7, n % 7), pix(n / 7 + 1, n % 7), pix(n / 7 + 2, n % 7));
    end
  endtask

  task automatic check_ramp(string tag, int start, int stall_pos, int stall_len, bit zero_k);
    int i, n, exp_t, exp_v;
    check($sformatf("%s count", tag), got_v.size(), 20);
    for (int gy = 0; gy < 4; gy++) begin
      for (int gx = 0; gx < 5; gx++) begin
        i     = gy * 5 + gx;
        n     = gy * 7 + gx + 2;
        exp_t = start + n + ((n >= stall_pos) ? stall_len : 0) + 4;
        exp_v = zero_k ? 0 : 537 + 45 * gx + 315 * gy;
        if (i < got_v.size()) begin
          check($sformatf("%s value %0d", tag, i), got_v[i], exp_v);
          check($sformatf("%s time %0d", tag, i), got_t[i], exp_t);
        end
      end
    end
  endtask

  task automatic set_ramp_kernel();
    for (int i = 0; i < 9; i++) k[i] = 8'(i + 1);
  endtask

  int start;

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.px0      = '0;
    bus.px1      = '0;
    bus.px2      = '0;
    for (int i = 0; i < 9; i++) k[i] = '0;
    #2;
    check("reset out_valid", bus.out_valid, 0);
    check("reset out_pixel", bus.out_pixel, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Ramp image, continuous stream.
    set_ramp_kernel();
    got_v.delete();
    got_t.delete();
    start = cyc + 1;
    run_ramp(-1, 0);
    idle(8);
    check_ramp("ramp", start, -1, 0, 1'b0);
    check("ramp idle out_valid", bus.out_valid, 0);
    check("ramp hold out_pixel", bus.out_pixel, 1662);

    // Full-scale pixels and weights.
    for (int i = 0; i < 9; i++) k[i] = 8'd255;
    got_v.delete();
    got_t.delete();
    start = cyc + 1;
    repeat (7) send(255, 255, 255);
    idle(8);
    check("max count", got_v.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_v.size()) begin
        check($sformatf("max value %0d", i), got_v[i], 585225);
        check($sformatf("max time %0d", i), got_t[i], start + i + 2 + 4);
      end
    end

    // Three-cycle stall before column 3 of the second row.
    set_ramp_kernel();
    got_v.delete();
    got_t.delete();
    start = cyc + 1;
    run_ramp(10, 3);
    idle(8);
    check_ramp("stall", start, 10, 3, 1'b0);

    // Reset after four columns, two windows still in flight.
    got_v.delete();
    got_t.delete();
    for (int x = 0; x < 4; x++) send(pix(0, x), pix(1, x), pix(2, x));
    rst = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset out_pixel", bus.out_pixel, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    check("midreset discarded", got_v.size(), 0);
    start = cyc + 1;
    for (int x = 0; x < 7; x++) send(pix(0, x), pix(1, x), pix(2, x));
    idle(8);
    check("midreset count", got_v.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_v.size()) begin
        check($sformatf("midreset value %0d", i), got_v[i], 537 + 45 * i);
        check($sformatf("midreset time %0d", i), got_t[i], start + i + 2 + 4);
      end
    end

    // Zero kernel on the ramp image.
    for (int i = 0; i < 9; i++) k[i] = '0;
    got_v.delete();
    got_t.delete();
    start = cyc + 1;
    run_ramp(-1, 0);
    idle(8);
    check_ramp("zero", start, -1, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_3x3_systolic.md
# conv_3x3_systolic

Streaming 3×3 convolution engine for the first convolution layer of the stream-based inference pipeline. Each cycle it accepts one image column of three vertically adjacent 8-bit pixels, keeps a 3-column sliding window, and multiplies it by a static 3×3 unsigned kernel. It emits one 24-bit sum per fully populated window after a fixed pipeline latency. Upstream line buffers supply the three rows; downstream activation/pooling consumes `out_pixel`.

## Interface
- `IMG_W`, default 7: image width in pixels. Sets the number of columns per row and the row-wrap point (minimum 3).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (low = reset).
- `in_valid` input 1: the column on `px0..px2` is valid this cycle.
- `px0` input 8: pixel of row y-2 (window top row), unsigned.
- `px1` input 8: pixel of row y-1 (middle row).
- `px2` input 8: pixel of row y (bottom row).
- `k00..k22` input 8 each: kernel weights, unsigned. `kRC` is row R, column C. Column 0 multiplies the oldest column.
- `out_valid` output 1: `out_pixel` holds a new result.
- `out_pixel` output 24: unsigned convolution sum.

## Operation
- Result: out = Σ_{r,c} k_rc · P[r][c]. P[r][c] is row r (0=px0, 1=px1, 2=px2) of the c-th column of the window (c=0 oldest, c=2 newest).
- Arithmetic: 8×8 unsigned products (16 bit), summed at full precision. The maximum is 9·255·255 = 585225 < 2^24, so no saturation or truncation is needed. `out_pixel` is zero-extended.
- Column counter `col` (0..IMG_W-1): advances only on cycles with `in_valid`=1 and wraps from IMG_W-1 to 0.
- A window is complete when a valid column arrives with `col` ≥ 2 (value before the increment). That column generates exactly one output.
- Columns 0 and 1 of each row only fill the window. Windows spanning a row boundary are never emitted. Each row produces exactly IMG_W-2 outputs, in left-to-right, top-to-bottom order.
- `in_valid`=0 (stall):
  - the horizontal shift registers and `col` hold;
  - results already in flight keep draining and emit on schedule;
  - a stall never drops or duplicates a window.
- Kernel inputs must be stable while any window is in flight. They are not registered.
- `out_pixel` holds its last value while `out_valid`=0.

## Timing
- Reset (`rst` low, asynchronous):
  - `out_valid`=0 and `out_pixel`=0 immediately;
  - `col`=0, all shift, pipeline and valid registers cleared.
- After `rst` is released, the first window needs 3 new valid columns. Reset mid-row discards the partial window and all in-flight results.
- Latency is fixed at 4 cycles. If the completing column is sampled at edge t, then `out_valid`=1 with its result is registered at edge t+4.
  - Stage 1: input register.
  - Stage 2: nine products.
  - Stage 3: per-row sums.
  - Stage 4: final sum into the output register.
- Throughput: one column per cycle, so one result per cycle during the steady state of a row.
- `out_valid` is a one-cycle pulse per result and is never asserted for a non-window column. Back-to-back results give consecutive `out_valid` cycles.
- There is no backpressure; the consumer must accept every result.

## Structure
- Shared package `conv_pkg`: `PIX_W`=8, `ACC_W`=24, `CONV_LAT`=4, and the kernel weight type.
- One natural sub-module, `conv_row_pe`:
  - one kernel row: 3-tap horizontal shift register, three multipliers, row partial sum;
  - instantiated three times (px0/k0x, px1/k1x, px2/k2x).
- The top level holds the column counter, the valid pipeline and the final adder.

## Test plan
- Ramp image, 7×6, pixel(y,x) = 7y+x+1, kernel 1..9 row-major. Stream rows y≥2 with px0..px2 = rows y-2..y, in_valid continuous for 28 cycles:
  - exactly 20 outputs, out(gy,gx) = 537 + 45·gx + 315·gy;
  - first output 537, fifth 717, last 1662;
  - each first output arrives 4 cycles after its third column.
- Row boundary, same stream:
  - exactly 5 results per row;
  - no output for the 2 cycles of each new row's first two columns, apart from in-flight drain.
- Overflow range: all pixels and weights 255, one row of 7 columns → 5 outputs of 585225.
- Stall: deassert in_valid for 3 cycles mid-row in the ramp test → the same 20 values in the same order, each delayed by the stall length.
- Reset mid-row: pull `rst` low after 4 columns of a row →
  - `out_valid`=0 and `out_pixel`=0 at once, pending results discarded;
  - after release, the first new output appears only after 3 fresh columns + 4 cycles.
- Zero kernel (all k=0), ramp image → 20 outputs, all 0, with correct `out_valid` timing.
